icache_fetch: RTL and testbench

//  Direct-mapped, read-only instruction cache between PC and IF_ID, in place of the flat instruction memory.

---
 rtl/icache_fetch.sv | 165 ++++++++++++++++
 tb/tb_icache_fetch.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : icache_fetch
//  Brief    : Direct-mapped read-only instruction cache with same-cycle hits
//             and a per-word req/ack line refill from backing memory.
//  Revision : 1.0
// ============================================================================
module icache_fetch #(
  parameter int LINES      = 16,
  parameter int LINE_WORDS = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_i,
  input  logic [31:0]      addr_i,
  input  logic             inv_i,
  output logic [31:0]      inst_o,
  output logic             stall_o,
  output logic             mem_req_o,
  output logic [31:0]      mem_addr_o,
  input  logic             mem_ack_i,
  input  logic [31:0]      mem_data_i,
  output logic [CNT_W-1:0] miss_cnt_o
);

  localparam int c_off_w = $clog2(LINE_WORDS);
  localparam int c_idx_w = $clog2(LINES);
  localparam int c_tag_w = 30 - c_off_w - c_idx_w;
  localparam logic [c_off_w-1:0] c_last_beat = c_off_w'(LINE_WORDS - 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_REFILL = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [31:0]        r_data [LINES][LINE_WORDS];
  logic [c_tag_w-1:0] r_tags [LINES];
  logic [LINES-1:0]   r_valid;
  logic               r_inv_pending;
  logic               r_mem_req;
  logic [31:0]        r_mem_addr;
  logic [c_off_w-1:0] r_beat;
  logic [CNT_W-1:0]   r_miss_cnt;
  logic [c_idx_w-1:0] r_fill_idx;
  logic [c_tag_w-1:0] r_fill_tag;

  logic [c_off_w-1:0] w_off;
  logic [c_idx_w-1:0] w_idx;
  logic [c_tag_w-1:0] w_tag;
  logic               w_hit;
  logic               w_start;
  logic               w_ack;
  logic               w_last;
  logic               w_unused_addr;

  assign w_off         = addr_i[2 +: c_off_w];
  assign w_idx         = addr_i[2 + c_off_w +: c_idx_w];
  assign w_tag         = addr_i[31 -: c_tag_w];
  assign w_unused_addr = ^addr_i[1:0];

  assign w_hit   = req_i & r_valid[w_idx] & (r_tags[w_idx] == w_tag) & (r_state == ST_IDLE);
  assign stall_o = req_i & ~w_hit;
  assign inst_o  = w_hit ? r_data[w_idx][w_off] : 32'h0;

  assign mem_req_o  = r_mem_req;
  assign mem_addr_o = r_mem_addr;
  assign miss_cnt_o = r_miss_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_ack        = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (stall_o) begin
          w_start      = 1'b1;
          w_state_next = ST_REFILL;
        end
      end
      ST_REFILL: begin
        // Acks only count while a request is actually outstanding.
        if (mem_ack_i && r_mem_req) begin
          w_ack = 1'b1;
          if (r_beat == c_last_beat) begin
            w_last       = 1'b1;
            w_state_next = ST_IDLE;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid       <= '0;
      r_inv_pending <= 1'b0;
      r_mem_req     <= 1'b0;
      r_mem_addr    <= 32'h0;
      r_beat        <= '0;
      r_miss_cnt    <= '0;
    end else begin
      if (w_start) begin
        r_mem_req  <= 1'b1;
        r_mem_addr <= {addr_i[31:2+c_off_w], {(2 + c_off_w){1'b0}}};
        r_beat     <= '0;
        if (r_miss_cnt != '1) begin
          r_miss_cnt <= r_miss_cnt + CNT_W'(1);
        end
      end
      if (w_ack) begin
        r_mem_addr <= r_mem_addr + 32'd4;
        r_beat     <= r_beat + c_off_w'(1);
        if (w_last) begin
          r_mem_req <= 1'b0;
        end
      end

      if (w_last) begin
        r_inv_pending <= 1'b0;
      end else if ((r_state == ST_REFILL) && inv_i) begin
        r_inv_pending <= 1'b1;
      end

      // An invalidate arriving on the final beat still suppresses the new line.
      if ((r_state == ST_IDLE) && inv_i) begin
        r_valid <= '0;
      end else if (w_last) begin
        if (r_inv_pending || inv_i) begin
          r_valid <= '0;
        end else begin
          r_valid[r_fill_idx] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_start) begin
      r_fill_idx <= w_idx;
      r_fill_tag <= w_tag;
    end
    if (w_ack) begin
      r_data[r_fill_idx][r_beat] <= mem_data_i;
    end
    if (w_last) begin
      r_tags[r_fill_idx] <= r_fill_tag;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_icache_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_icache_fetch
//  Brief    : Self-checking bench for icache_fetch against a line-level model.
//  Revision : 1.0
// ============================================================================
module tb_icache_fetch;

  localparam int LINES      = 16;
  localparam int LINE_WORDS = 4;
  localparam int CNT_W      = 16;

  logic             clk;
  logic             rst_i;
  logic             req_i;
  logic [31:0]      addr_i;
  logic             inv_i;
  logic [31:0]      inst_o;
  logic             stall_o;
  logic             mem_req_o;
  logic [31:0]      mem_addr_o;
  logic             mem_ack_i;
  logic [31:0]      mem_data_i;
  logic [CNT_W-1:0] miss_cnt_o;

  int checks = 0;
  int errors = 0;

  icache_fetch #(.LINES(LINES), .LINE_WORDS(LINE_WORDS), .CNT_W(CNT_W)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .req_i      (req_i),
    .addr_i     (addr_i),
    .inv_i      (inv_i),
    .inst_o     (inst_o),
    .stall_o    (stall_o),
    .mem_req_o  (mem_req_o),
    .mem_addr_o (mem_addr_o),
    .mem_ack_i  (mem_ack_i),
    .mem_data_i (mem_data_i),
    .miss_cnt_o (miss_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Backing memory: directed contents where given, a fixed hash elsewhere.
  logic [31:0] mem_init [logic [31:0]];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_init.exists(a)) return mem_init[a];
    return {a[15:0] ^ 16'h1234, a[15:0]};
  endfunction

  function automatic logic [31:0] line_base(input logic [31:0] a);
    return a & ~32'(LINE_WORDS * 4 - 1);
  endfunction

  function automatic int line_idx(input logic [31:0] a);
    return int'((a / (LINE_WORDS * 4)) % LINES);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Responder: acks after a programmable gap, optional stray acks when idle.
  int  max_gap   = 0;
  bit  fixed_gap = 1'b1;
  bit  stray_en  = 1'b0;
  int  wait_left = 0;

  function automatic int pick_gap();
    return fixed_gap ? max_gap : int'($urandom_range(0, max_gap));
  endfunction

  initial begin
    mem_ack_i  = 1'b0;
    mem_data_i = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      if (mem_req_o) begin
        if (wait_left == 0) begin
          mem_ack_i  = 1'b1;
          mem_data_i = mem_word(mem_addr_o);
          wait_left  = pick_gap();
        end else begin
          mem_ack_i  = 1'b0;
          mem_data_i = $urandom;
          wait_left--;
        end
      end else begin
        mem_ack_i  = stray_en;
        mem_data_i = 32'hDEAD_0000 | 32'($urandom_range(0, 16'hFFFF));
        wait_left  = pick_gap();
      end
    end
  end

  // Line-level reference model, checked every negedge then advanced.
  bit          m_on = 1'b0;
  bit          m_valid [LINES];
  logic [31:0] m_base  [LINES];
  bit          m_busy;
  bit          m_pend;
  logic [31:0] m_rbase;
  int          m_rcount;
  int          m_misses;

  initial begin
    bit hit;
    int ix;
    forever begin
      @(negedge clk);
      ix  = line_idx(addr_i);
      hit = req_i && !m_busy && m_valid[ix] && (m_base[ix] == line_base(addr_i));
      if (m_on) begin
        check("model stall_o", 32'(stall_o), 32'(req_i && !hit));
        check("model inst_o", inst_o, hit ? mem_word(addr_i & ~32'h3) : 32'h0);
        check("model mem_req_o", 32'(mem_req_o), 32'(m_busy));
        check("model miss_cnt_o", 32'(miss_cnt_o), 32'(m_misses));
        if (m_busy) check("model mem_addr_o", mem_addr_o, m_rbase + 32'(4 * m_rcount));
      end
      if (rst_i) begin
        m_busy = 0; m_pend = 0; m_misses = 0; m_rcount = 0;
        foreach (m_valid[i]) m_valid[i] = 0;
        m_on = 1'b1;
      end else if (!m_busy) begin
        if (inv_i) foreach (m_valid[i]) m_valid[i] = 0;
        if (req_i && !hit) begin
          m_busy   = 1;
          m_rbase  = line_base(addr_i);
          m_rcount = 0;
          if (m_misses < (1 << CNT_W) - 1) m_misses++;
        end
      end else begin
        if (inv_i) m_pend = 1;
        if (mem_ack_i) begin
          m_rcount++;
          if (m_rcount == LINE_WORDS) begin
            m_busy = 0;
            if (m_pend) begin
              foreach (m_valid[i]) m_valid[i] = 0;
            end else begin
              m_valid[line_idx(m_rbase)] = 1;
              m_base[line_idx(m_rbase)]  = m_rbase;
            end
            m_pend = 0;
          end
        end
      end
    end
  end

  task automatic wait_hit(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (stall_o && n < budget);
    if (stall_o) begin
      checks++; errors++;
      $display("FAIL wait_hit timeout: stall_o still %b after %0d cycles", stall_o, budget);
    end
  endtask

  task automatic wait_ack(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(mem_req_o && mem_ack_i) && n < budget);
    if (!(mem_req_o && mem_ack_i)) begin
      checks++; errors++;
      $display("FAIL wait_ack timeout: no ack within %0d cycles", budget);
    end
  endtask

  task automatic wait_req_low(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (mem_req_o && n < budget);
    if (mem_req_o) begin
      checks++; errors++;
      $display("FAIL wait_req_low timeout: mem_req_o still high after %0d cycles", budget);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      mem_init[32'h40  + 32'(4 * i)] = 32'hA0 + 32'(i);
      mem_init[32'h140 + 32'(4 * i)] = 32'hB0 + 32'(i);
      mem_init[32'h80  + 32'(4 * i)] = 32'hC0 + 32'(i);
      mem_init[32'h200 + 32'(4 * i)] = 32'hD0 + 32'(i);
      mem_init[32'h300 + 32'(4 * i)] = 32'hE0 + 32'(i);
    end
    rst_i = 1'b1; req_i = 1'b0; addr_i = 32'h0; inv_i = 1'b0;
    tick(); tick();
    req_i = 1'b1; addr_i = 32'h40;
    @(negedge clk);
    check("reset stall_o", 32'(stall_o), 32'h1);
    check("reset inst_o", inst_o, 32'h0);
    check("reset mem_req_o", 32'(mem_req_o), 32'h0);
    check("reset mem_addr_o", mem_addr_o, 32'h0);
    check("reset miss_cnt_o", 32'(miss_cnt_o), 32'h0);

    // Cold miss, back-to-back acks.
    tick(); rst_i = 1'b0;
    @(negedge clk);
    check("cold stall_o", 32'(stall_o), 32'h1);
    tick();
    @(negedge clk);
    check("cold mem_req_o", 32'(mem_req_o), 32'h1);
    check("cold mem_addr_o", mem_addr_o, 32'h40);
    wait_hit(20);
    check("cold inst_o", inst_o, 32'hA0);
    check("cold miss_cnt_o", 32'(miss_cnt_o), 32'h1);

    tick(); addr_i = 32'h48;
    @(negedge clk);
    check("hit stall_o", 32'(stall_o), 32'h0);
    check("hit inst_o", inst_o, 32'hA2);
    check("hit mem_req_o", 32'(mem_req_o), 32'h0);

    // Conflict on the same index.
    tick(); addr_i = 32'h140;
    wait_hit(20);
    check("conflict inst_o", inst_o, 32'hB0);
    tick(); addr_i = 32'h40;
    @(negedge clk);
    check("conflict re-miss stall_o", 32'(stall_o), 32'h1);
    wait_hit(20);
    check("conflict inst_o 0x40", inst_o, 32'hA0);
    check("conflict miss_cnt_o", 32'(miss_cnt_o), 32'h3);

    // Three idle cycles between acks.
    max_gap = 3;
    tick(); addr_i = 32'h84;
    wait_hit(60);
    check("gap inst_o", inst_o, 32'hC1);
    max_gap = 0;

    // Invalidate during the second beat.
    tick(); addr_i = 32'h200;
    wait_ack(20);
    tick(); inv_i = 1'b1;
    tick(); inv_i = 1'b0;
    wait_req_low(20);
    check("inv refill re-miss stall_o", 32'(stall_o), 32'h1);
    wait_hit(20);
    check("inv refetch inst_o", inst_o, 32'hD0);
    tick(); addr_i = 32'h48;
    @(negedge clk);
    check("inv old line stall_o", 32'(stall_o), 32'h1);
    wait_hit(20);
    check("inv old line inst_o", inst_o, 32'hA2);

    // Reset after the second ack, then a stray ack.
    tick(); addr_i = 32'h300;
    wait_ack(20);
    wait_ack(20);
    tick(); rst_i = 1'b1;
    tick(); rst_i = 1'b0; req_i = 1'b0; stray_en = 1'b1;
    @(negedge clk);
    check("rst mid mem_req_o", 32'(mem_req_o), 32'h0);
    check("rst mid miss_cnt_o", 32'(miss_cnt_o), 32'h0);
    tick(); req_i = 1'b1; stray_en = 1'b0;
    @(negedge clk);
    check("rst mid stray ignored mem_req_o", 32'(mem_req_o), 32'h0);
    tick();
    @(negedge clk);
    check("rst refetch mem_req_o", 32'(mem_req_o), 32'h1);
    check("rst refetch mem_addr_o", mem_addr_o, 32'h300);
    wait_hit(20);
    check("rst refetch inst_o", inst_o, 32'hE0);

    // Randomized traffic over a small address window to force conflicts.
    fixed_gap = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      rst_i    = ($urandom_range(0, 199) == 0);
      inv_i    = ($urandom_range(0, 49) == 0);
      req_i    = ($urandom_range(0, 9) != 0);
      stray_en = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) addr_i = 32'($urandom_range(0, 32'h7FF));
      if ($urandom_range(0, 99) == 0) max_gap = int'($urandom_range(0, 3));
    end
    tick();
    rst_i = 1'b0; inv_i = 1'b0; stray_en = 1'b0;
    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
